// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - index decoder (one-hot/thermometer/one-cold) behind a stallable pipeline
// Every stage shares the same advance condition, so one stall freezes the whole pipe.
module decoder_pipe #(
  parameter int DOUT_WIDTH = 16,
  parameter int DIN_WIDTH  = $clog2(DOUT_WIDTH),
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic [1:0]            mode,
  input  logic                  din_v,
  output logic                  din_rdy,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_v,
  input  logic                  dout_rdy,
  output logic                  dout_err,
  output logic [7:0]            err_cnt
);

  logic [31:0]           idx;
  logic [DOUT_WIDTH-1:0] dec_word;
  logic                  dec_err;

  logic [DOUT_WIDTH-1:0] word_q [LATENCY];
  logic [LATENCY-1:0]    valid_q;
  logic [LATENCY-1:0]    err_q;

  assign idx     = 32'(din);
  assign din_rdy = !dout_v || dout_rdy;

  // Range check happens before any bit is built, so no index beyond the word is ever used.
  always_comb begin
    dec_word = '0;
    dec_err  = 1'b0;
    if (mode == 2'd3 || idx >= DOUT_WIDTH) begin
      dec_err = 1'b1;
    end else begin
      for (int k = 0; k < DOUT_WIDTH; k++) begin
        case (mode)
          2'd0:    dec_word[k] = (idx == k[31:0]);
          2'd1:    dec_word[k] = (k[31:0] <= idx);
          2'd2:    dec_word[k] = (idx != k[31:0]);
          default: dec_word[k] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        word_q[i] <= '0;
      end
      valid_q <= '0;
      err_q   <= '0;
    end else if (din_rdy) begin
      valid_q[0] <= din_v;
      word_q[0]  <= din_v ? dec_word : '0;
      err_q[0]   <= din_v && dec_err;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        word_q[i]  <= word_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 8'd0;
    end else if (din_v && din_rdy && dec_err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign dout     = word_q[LATENCY-1];
  assign dout_v   = valid_q[LATENCY-1];
  assign dout_err = err_q[LATENCY-1];

endmodule

// File: tb/tb_decoder_pipe.sv
// tb/tb_decoder_pipe.sv - directed bench for decoder_pipe
// Four instances share stimulus: 16-bit at LATENCY 1/2/4 and a 10-bit at LATENCY 2.
module tb_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = '0;
  logic [1:0] mode = '0;
  logic       din_v = 1'b0;
  logic       dout_rdy = 1'b1;

  int total = 0;
  int bad   = 0;

  logic        rdy_l1, v_l1, err_l1;
  logic [15:0] dout_l1;
  logic [7:0]  cnt_l1;
  logic        rdy_l2, v_l2, err_l2;
  logic [15:0] dout_l2;
  logic [7:0]  cnt_l2;
  logic        rdy_l4, v_l4, err_l4;
  logic [15:0] dout_l4;
  logic [7:0]  cnt_l4;
  logic        rdy_w10, v_w10, err_w10;
  logic [9:0]  dout_w10;
  logic [7:0]  cnt_w10;

  always #5 clk = ~clk;

  decoder_pipe #(.DOUT_WIDTH(16), .DIN_WIDTH(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .din_v(din_v), .din_rdy(rdy_l1),
    .dout(dout_l1), .dout_v(v_l1), .dout_rdy(dout_rdy), .dout_err(err_l1), .err_cnt(cnt_l1));
  decoder_pipe #(.DOUT_WIDTH(16), .DIN_WIDTH(4), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .din_v(din_v), .din_rdy(rdy_l2),
    .dout(dout_l2), .dout_v(v_l2), .dout_rdy(dout_rdy), .dout_err(err_l2), .err_cnt(cnt_l2));
  decoder_pipe #(.DOUT_WIDTH(16), .DIN_WIDTH(4), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .din_v(din_v), .din_rdy(rdy_l4),
    .dout(dout_l4), .dout_v(v_l4), .dout_rdy(dout_rdy), .dout_err(err_l4), .err_cnt(cnt_l4));
  decoder_pipe #(.DOUT_WIDTH(10), .DIN_WIDTH(4), .LATENCY(2)) u_w10 (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .din_v(din_v), .din_rdy(rdy_w10),
    .dout(dout_w10), .dout_v(v_w10), .dout_rdy(dout_rdy), .dout_err(err_w10), .err_cnt(cnt_w10));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; din_v = 1'b0; din = '0; mode = '0; dout_rdy = 1'b1;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [26:0] obs;
    din_v = 1'b0;
    rst = 1'b0;
    #2;
    obs = {v_l2, dout_l2, err_l2, cnt_l2, rdy_l2};
    total++;
    if (obs !== {1'b0, 16'h0, 1'b0, 8'h0, 1'b1}) begin
      bad++;
      $display("FAIL reset_l2 got=%h exp=%h", obs, {1'b0, 16'h0, 1'b0, 8'h0, 1'b1});
    end
    obs = {v_l4, dout_l4, err_l4, cnt_l4, rdy_l4};
    total++;
    if (obs !== {1'b0, 16'h0, 1'b0, 8'h0, 1'b1}) begin
      bad++;
      $display("FAIL reset_l4 got=%h exp=%h", obs, {1'b0, 16'h0, 1'b0, 8'h0, 1'b1});
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_onehot_stream();
    logic [17:0] obs, exp;
    int lat;
    apply_reset();
    mode = 2'd0;
    dout_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 3; k++) begin
        lat = (k == 0) ? 1 : (k == 1) ? 2 : 4;
        obs = (k == 0) ? {v_l1, dout_l1, err_l1} :
              (k == 1) ? {v_l2, dout_l2, err_l2} : {v_l4, dout_l4, err_l4};
        if (c >= lat && c - lat < 16) exp = {1'b1, 16'(1) << (c - lat), 1'b0};
        else                          exp = '0;
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL onehot_stream lat=%0d cycle=%0d got=%h exp=%h", lat, c, obs, exp);
        end
      end
      din_v = (c < 16);
      din   = 4'(c);
      step();
    end
    din_v = 1'b0;
    total++;
    if ({cnt_l1, cnt_l2, cnt_l4} !== 24'h0) begin
      bad++;
      $display("FAIL onehot_err_cnt got=%h exp=000000", {cnt_l1, cnt_l2, cnt_l4});
    end
  endtask

  task automatic test_modes();
    logic [1:0]  m_tab [3] = '{2'd1, 2'd2, 2'd3};
    logic [15:0] d_tab [3] = '{16'h000F, 16'hFFF7, 16'h0000};
    logic        e_tab [3] = '{1'b0, 1'b0, 1'b1};
    logic [17:0] obs, exp;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      if (c >= 2 && c < 5) begin
        obs = {v_l2, dout_l2, err_l2};
        exp = {1'b1, d_tab[c-2], e_tab[c-2]};
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL modes idx=%0d got=%h exp=%h", c - 2, obs, exp);
        end
      end
      din_v = (c < 3);
      mode  = (c < 3) ? m_tab[c] : 2'd0;
      din   = 4'd3;
      step();
    end
    din_v = 1'b0;
    total++;
    if (cnt_l2 !== 8'd1) begin
      bad++;
      $display("FAIL modes_err_cnt got=%0d exp=1", cnt_l2);
    end
  endtask

  task automatic test_width10();
    logic [3:0]  i_tab [3] = '{4'd9, 4'd10, 4'd15};
    logic [9:0]  d_tab [3] = '{10'h200, 10'h000, 10'h000};
    logic        e_tab [3] = '{1'b0, 1'b1, 1'b1};
    logic [11:0] obs, exp;
    apply_reset();
    mode = 2'd0;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2 && c < 5) begin
        obs = {v_w10, dout_w10, err_w10};
        exp = {1'b1, d_tab[c-2], e_tab[c-2]};
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL width10 idx=%0d got=%h exp=%h", c - 2, obs, exp);
        end
      end
      din_v = (c < 3);
      din   = (c < 3) ? i_tab[c] : 4'd0;
      step();
    end
    din_v = 1'b0;
    total++;
    if (cnt_w10 !== 8'd2) begin
      bad++;
      $display("FAIL width10_err_cnt got=%0d exp=2", cnt_w10);
    end
  endtask

  task automatic test_stall();
    logic        t_v  [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [3:0]  t_d  [9] = '{1, 2, 3, 4, 4, 4, 0, 0, 0};
    logic        t_r  [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    logic        x_v  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [15:0] x_d  [9] = '{16'h0, 16'h0, 16'h2, 16'h4, 16'h4, 16'h4, 16'h4, 16'h8, 16'h0};
    logic        x_r  [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    logic [18:0] obs, exp;
    apply_reset();
    mode = 2'd0;
    for (int c = 0; c < 9; c++) begin
      din_v = t_v[c]; din = t_d[c]; dout_rdy = t_r[c];
      #1;
      obs = {v_l2, dout_l2, err_l2, rdy_l2};
      exp = {x_v[c], x_d[c], 1'b0, x_r[c]};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL stall cycle=%0d got=%h exp=%h", c, obs, exp);
      end
      step();
    end
    din_v = 1'b0;
    dout_rdy = 1'b1;
  endtask

  task automatic test_err_saturate();
    logic [17:0] obs;
    apply_reset();
    mode = 2'd3; din = 4'd3; din_v = 1'b1; dout_rdy = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254 || i == 255 || i == 300) begin
        total++;
        if (cnt_l2 !== ((i == 254) ? 8'd254 : 8'd255)) begin
          bad++;
          $display("FAIL err_saturate n=%0d got=%0d exp=%0d", i, cnt_l2, (i == 254) ? 254 : 255);
        end
      end
    end
    obs = {v_l2, dout_l2, err_l2};
    total++;
    if (obs !== {1'b1, 16'h0, 1'b1}) begin
      bad++;
      $display("FAIL reserved_out got=%h exp=%h", obs, {1'b1, 16'h0, 1'b1});
    end
    din_v = 1'b0;
    mode = 2'd0;
  endtask

  task automatic test_async_reset();
    logic [25:0] obs;
    apply_reset();
    din_v = 1'b1; mode = 2'd3; din = 4'd5;
    step();
    mode = 2'd0; din = 4'd6;
    step();
    din_v = 1'b0;
    obs = {v_l2, dout_l2, err_l2, cnt_l2};
    total++;
    if (obs !== {1'b1, 16'h0, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL inflight got=%h exp=%h", obs, {1'b1, 16'h0, 1'b1, 8'd1});
    end
    #2;
    rst = 1'b0;
    #1;
    obs = {v_l2, dout_l2, err_l2, cnt_l2};
    total++;
    if (obs !== 26'h0 || rdy_l2 !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_l2 got=%h rdy=%b exp=0 rdy=1", obs, rdy_l2);
    end
    total++;
    if ({v_l4, dout_l4, err_l4, cnt_l4} !== 26'h0) begin
      bad++;
      $display("FAIL async_reset_l4 got=%h exp=0", {v_l4, dout_l4, err_l4, cnt_l4});
    end
    step();
    step();
    #2;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if ({v_l1, v_l2, v_l4, dout_l1, dout_l2, dout_l4} !== '0) begin
        bad++;
        $display("FAIL stale_after_reset cycle=%0d got v=%b%b%b exp v=000", c, v_l1, v_l2, v_l4);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_onehot_stream();
    test_modes();
    test_width10();
    test_stall();
    test_err_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 SHALL have parameter DOUT_WIDTH, default 16, number of decoded output bits (legal 2..256, need not be a power of two).
REQ-002 SHALL have parameter DIN_WIDTH, default $clog2(DOUT_WIDTH), index width.
REQ-003 SHALL have parameter LATENCY, default 2, number of pipeline register stages from accepted input to dout (legal 1..4).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port din  input  DIN_WIDTH  index to decode.
REQ-007 SHALL have port mode  input  2  decode mode, sampled with din.
REQ-008 SHALL have port din_v  input  1  din/mode valid.
REQ-009 SHALL have port din_rdy  output  1  block can accept din this cycle.
REQ-010 SHALL have port dout  output  DOUT_WIDTH  decoded word.
REQ-011 SHALL have port dout_v  output  1  dout valid.
REQ-012 SHALL have port dout_rdy  input  1  downstream accepts dout.
REQ-013 SHALL have port dout_err  output  1  qualifies dout: index out of range or reserved mode.
REQ-014 SHALL have port err_cnt  output  8  saturating count of accepted erroneous inputs.

Function
REQ-015 Input transfer SHALL occur on a rising clk edge where din_v=1 and din_rdy=1; output transfer where dout_v=1 and dout_rdy=1.
REQ-016 din_rdy SHALL equal (!dout_v || dout_rdy), combinationally; no other dependency.
REQ-017 Pipeline SHALL be LATENCY stages of {valid, word, err}; when din_rdy=1 all stages advance, stage 1 loading din_v and the decoded word; when din_rdy=0 all stages hold.
REQ-018 An input accepted at edge N with no stall SHALL appear on dout/dout_v/dout_err after edge N+LATENCY-1, i.e. visible LATENCY cycles after presentation; each stall cycle adds exactly one cycle.
REQ-019 Bubbles (din_v=0 while advancing) SHALL propagate as dout_v=0 slots; bubbles are not collapsed.
REQ-020 mode=0 (one-hot): dout[din]=1, all other bits 0.
REQ-021 mode=1 (thermometer): dout[k]=1 for all k<=din, others 0.
REQ-022 mode=2 (one-cold): dout[din]=0, all other bits 1.
REQ-023 mode=3 (reserved): dout=0, dout_err=1.
REQ-024 din>=DOUT_WIDTH in any mode SHALL give dout=0, dout_err=1; decode uses no bits beyond DOUT_WIDTH-1.
REQ-025 dout and dout_err SHALL be 0 whenever dout_v=0 (stage word cleared when loading a bubble).
REQ-026 dout/dout_v/dout_err SHALL remain stable while dout_v=1 and dout_rdy=0.
REQ-027 err_cnt SHALL increment by 1 on each input transfer whose decode sets err; SHALL saturate at 255 and never wrap.
REQ-028 All outputs SHALL come directly from registers except din_rdy.

Reset
REQ-029 rst=0 SHALL asynchronously clear all pipeline stages and err_cnt: dout=0, dout_v=0, dout_err=0, err_cnt=0; din_rdy=1 (follows from dout_v=0).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight words; no partial word emerges after release.
REQ-031 First input transfer SHALL be possible on the first rising clk edge after rst deasserts.

Verification
REQ-032 DOUT_WIDTH=16, LATENCY=2, dout_rdy=1, mode=0, din_v=1, din=0..15 one per cycle -> dout=0x0001,0x0002,...,0x8000 in order, dout_v=1 continuous, dout_err=0, err_cnt=0.
REQ-033 mode=1 din=3 -> dout=0x000F; mode=2 din=3 -> dout=0xFFF7; mode=3 din=3 -> dout=0x0000, dout_err=1, err_cnt=1.
REQ-034 DOUT_WIDTH=10, mode=0, din=9 -> dout=0x200, err=0; din=10 and din=15 -> dout=0x000, dout_err=1, err_cnt=2.
REQ-035 Stream din=1,2,3 with dout_rdy=0 for 3 cycles while din=2 is on dout -> din_rdy=0 for those cycles, dout=0x0004 held stable, no word lost or duplicated, output order 0x0002,0x0004,0x0008.
REQ-036 Apply 300 reserved-mode inputs -> err_cnt reaches 255 and stays 255.
REQ-037 Assert rst=0 asynchronously (off clock edge) with 2 words in flight -> dout_v, dout, dout_err, err_cnt read 0 immediately; after release no stale word appears; repeat test REQ-032 for LATENCY=1 and LATENCY=4, checking exact latency.
